// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
// State encoding and a constant-foldable ceil-log2.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Ceil log2 with a floor of one bit, usable in port widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority picker: first asserted request after the last owner.
// Purely combinational; idx is meaningful only when any is set.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic               any_o,
    output logic [IW-1:0]      idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    // Scan last+1, last+2, ... wrapping mod NUM_REQ; keep the first hit.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among producers.
// A grant lasts up to MAX_BURST beats; a full fifo stalls but never releases.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_din,
    input  logic                       fifo_full,
    output logic                       grant_valid,
    output logic [clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IW = clog2(NUM_REQ);
    localparam int BW = clog2(MAX_BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          owner_valid;
    logic          beat;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IW     (IW)
    ) u_pick (
        .req_i (req_valid),
        .last_i(last_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Beat and output muxes derive only from registered grant state.
    assign owner_valid = req_valid[grant_q];
    assign beat        = (state_q == ST_BUSY) & owner_valid
                       & ~fifo_full & ~rst;
    assign fifo_wr_en  = beat;
    assign fifo_din    = req_data[grant_q*WIDTH +: WIDTH];
    assign req_ready   = beat ? (NUM_REQ'(1) << grant_q) : '0;
    assign grant_valid = (state_q == ST_BUSY);
    assign grant_id    = grant_q;

    // Next grant state: arbitrate in IDLE, count beats in BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!owner_valid) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Grant registers; reset makes producer 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter with a behavioural depth-8 fifo.
// Expected words are queued at issue; a monitor checks every write.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_din;
    logic           fifo_full = 1'b0;
    logic           grant_valid;
    logic [1:0]     grant_id;

    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   fcnt = 0;
    logic rd_req = 1'b0;
    logic fw, fr;

    logic [31:0] src_q [N][$];
    logic [31:0] exp_q [N][$];
    int wr_cyc [$];
    int gnt_id [$];
    int gnt_cyc [$];
    int burst_q [$];
    int fall_cyc = 0;
    int cur_beats = 0;
    logic gv_prev = 1'b0;

    fifo_wr_arbiter #(
        .NUM_REQ  (N),
        .WIDTH    (W),
        .MAX_BURST(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always #4 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     nm, act, act, expv, expv);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < N; p++) s += exp_q[p].size();
        return s;
    endfunction

    task automatic issue(input int p, input logic [31:0] w);
        src_q[p].push_back(w);
        exp_q[p].push_back(w);
    endtask

    task automatic clear();
        for (int p = 0; p < N; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        wr_cyc.delete();
        gnt_id.delete();
        gnt_cyc.delete();
        burst_q.delete();
        fall_cyc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of producer behaviour: hold until accepted, else maybe gap.
    task automatic drive_cycle(input int gap_pct, input int rd_pct);
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (acc[p]) void'(src_q[p].pop_front());
            if (!(req_valid[p] && !acc[p])) begin
                if (src_q[p].size() > 0 &&
                    $urandom_range(99) >= gap_pct) begin
                    req_valid[p] = 1'b1;
                    req_data[p*W +: W] = src_q[p][0];
                end else begin
                    req_valid[p] = 1'b0;
                end
            end
        end
        rd_req = ($urandom_range(99) < rd_pct);
    endtask

    task automatic run_drain(input int gap, input int rd, input int maxc);
        int n = 0;
        while (pending() > 0 && n < maxc) begin
            drive_cycle(gap, rd);
            n++;
        end
        chk("drain_left", pending(), 0);
        repeat (3) drive_cycle(gap, rd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear();
    endtask

    // Behavioural fifo occupancy; data is checked at write time.
    initial forever begin
        @(negedge clk);
        fw = fifo_wr_en;
        fr = rd_req && (fcnt > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            fcnt = 0;
        end else begin
            if (fw && fcnt < DEPTH) fcnt++;
            if (fr) fcnt--;
        end
        fifo_full = (fcnt == DEPTH);
    end

    // Monitor: every write is matched against the owner's expected stream.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            gv_prev = 1'b0;
        end else begin
            if (grant_valid && !gv_prev) begin
                gnt_id.push_back(int'(grant_id));
                gnt_cyc.push_back(cyc);
                cur_beats = 0;
            end
            if (fifo_wr_en) begin
                chk("wr_while_full", fifo_full, 0);
                chk("ready_onehot", req_ready, 4'b0001 << grant_id);
                if (exp_q[grant_id].size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_write: p%0d wrote 0x%0h, expected none",
                             grant_id, fifo_din);
                end else begin
                    chk("wr_data", fifo_din, exp_q[grant_id].pop_front());
                end
                wr_cyc.push_back(cyc);
                cur_beats++;
            end
            if (!grant_valid && gv_prev) begin
                burst_q.push_back(cur_beats);
                fall_cyc = cyc;
            end
            gv_prev = grant_valid;
        end
    end

    initial begin
        #(8 * 40000);
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0, bad;
        int off [10] = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
        int bexp [3] = '{4, 4, 2};

        // Reset state with every producer requesting.
        req_valid = '1;
        @(negedge clk);
        chk("rst_gv", grant_valid, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_wr", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. Reset pulsed mid-burst.
        for (int k = 0; k < 4; k++) issue(1, 32'h100 + k);
        n = 0;
        while (wr_cyc.size() < 2 && n < 20) begin
            drive_cycle(0, 100);
            n++;
        end
        chk("t1_pre_writes", wr_cyc.size(), 2);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t1_rst_gv", grant_valid, 0);
        chk("t1_rst_wr", fifo_wr_en, 0);
        chk("t1_rst_ready", req_ready, 0);
        req_valid = '0;
        clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 32'h200);
        issue(3, 32'h300);
        run_drain(0, 100, 50);
        chk("t1_gnt_cnt", gnt_id.size(), 2);
        if (gnt_id.size() == 2) begin
            chk("t1_first_gnt", gnt_id[0], 0);
            chk("t1_second_gnt", gnt_id[1], 3);
        end

        // 2. Single producer p2 streams 1000..1009.
        do_reset();
        for (int k = 0; k < 10; k++) issue(2, 1000 + k);
        run_drain(0, 100, 100);
        chk("t2_writes", wr_cyc.size(), 10);
        if (wr_cyc.size() == 10 && gnt_cyc.size() > 0) begin
            for (int k = 0; k < 10; k++)
                chk("t2_wr_offset", wr_cyc[k] - gnt_cyc[0], off[k]);
            chk("t2_release", fall_cyc - gnt_cyc[0], 13);
        end
        chk("t2_bursts", burst_q.size(), 3);
        if (burst_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("t2_burst_len", burst_q[k], bexp[k]);
                chk("t2_gnt_id", gnt_id[k], 2);
            end
        end

        // 3. All producers valid continuously.
        do_reset();
        for (int k = 0; k < 8; k++)
            for (int p = 0; p < N; p++)
                issue(p, (p << 8) | k);
        run_drain(0, 100, 200);
        chk("t3_gnts", gnt_id.size(), 8);
        chk("t3_bursts", burst_q.size(), 8);
        if (gnt_id.size() == 8 && burst_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t3_order", gnt_id[k], k % N);
                chk("t3_burst_len", burst_q[k], 4);
            end
        end

        // 4. Full stall with p1 still valid.
        do_reset();
        for (int k = 0; k < 10; k++) issue(1, 32'h4000 + k);
        n = 0;
        do begin
            drive_cycle(0, 0);
            #1;
            n++;
        end while (fcnt < DEPTH && n < 60);
        chk("t4_filled", fcnt, DEPTH);
        drive_cycle(0, 0);
        bad = 0;
        repeat (20) begin
            drive_cycle(0, 0);
            #1;
            if (fifo_wr_en || req_ready[1] || !grant_valid || grant_id != 2'd1)
                bad++;
        end
        chk("t4_stall_bad", bad, 0);
        n0 = wr_cyc.size();
        drive_cycle(0, 100);
        repeat (10) drive_cycle(0, 0);
        chk("t4_one_write", wr_cyc.size() - n0, 1);
        chk("t4_left", exp_q[1].size(), 1);

        // 5. Early release by p3 while p0 waits.
        do_reset();
        exp_q[3].push_back(32'h3000);
        req_valid[3] = 1'b1;
        req_data[3*W +: W] = 32'h3000;
        #1;
        chk("t5_arb_idle", grant_valid, 0);
        tick();
        #1;
        chk("t5_p3_id", grant_id, 3);
        tick();
        exp_q[3].push_back(32'h3001);
        req_data[3*W +: W] = 32'h3001;
        exp_q[0].push_back(32'h0500);
        req_valid[0] = 1'b1;
        req_data[0 +: W] = 32'h0500;
        tick();
        req_valid[3] = 1'b0;
        #1;
        chk("t5_drop_wr", fifo_wr_en, 0);
        chk("t5_drop_gv", grant_valid, 1);
        tick();
        chk("t5_idle_gv", grant_valid, 0);
        tick();
        chk("t5_p0_gv", grant_valid, 1);
        chk("t5_p0_id", grant_id, 0);
        chk("t5_p0_wr", fifo_wr_en, 1);
        tick();
        req_valid[0] = 1'b0;
        repeat (3) tick();
        chk("t5_left", pending(), 0);

        // 6. Random concurrent traffic with random reads.
        do_reset();
        for (int k = 0; k < 50; k++)
            for (int p = 0; p < N; p++)
                issue(p, 32'h6000_0000 | (p << 16) | k);
        run_drain(30, 50, 4000);
        chk("t6_writes", wr_cyc.size(), 200);

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule
